// File: rtl/warp_pkg.sv
// Shared types and constants for the warp dispatch block.
package warp_pkg;

    localparam int NUM_LANES_DEFAULT           = 8;
    localparam int DISPATCH_FIFO_DEPTH_DEFAULT = 4;
    localparam int INSTR_W                     = 32;
    localparam int COUNT_W                     = 16;

    // Dispatcher control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2
    } dispatch_state_e;

    // Issue counter step; wraps 0xFFFF back to 0 by construction.
    function automatic logic [COUNT_W-1:0] count_inc(input logic [COUNT_W-1:0] value);
        return value + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a combinational head view, used as the
// instruction queue. Flush and reset both empty it at the next edge.
module sync_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]            wr_ptr_reg;
    logic [PTR_W-1:0]            rd_ptr_reg;
    logic [CNT_W-1:0]            count_reg;
    logic [DEPTH-1:0][WIDTH-1:0] entries;
    logic                        push_ok;
    logic                        pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Each entry is its own register; the head is selected by the read pointer
    // so the dispatcher can inspect it in the same cycle.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [WIDTH-1:0] data_reg;

        // Capture the pushed word when the write pointer addresses this slot.
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                data_reg <= wdata;
            end
        end

        assign entries[gi] = data_reg;
    end

    assign rdata = entries[rd_ptr_reg];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/warp_dispatch.sv
// Queues {instruction, lane mask} pairs and issues them one at a time to a
// lane array, waiting for the lanes to report ready between issues.
module warp_dispatch
    import warp_pkg::*;
#(
    parameter int NUM_LANES  = NUM_LANES_DEFAULT,
    parameter int FIFO_DEPTH = DISPATCH_FIFO_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INSTR_W-1:0]   in_instr,
    input  logic [NUM_LANES-1:0] in_mask,
    input  logic                 flush,
    output logic                 execute,
    output logic [INSTR_W-1:0]   instruction,
    output logic [NUM_LANES-1:0] lane_enable,
    input  logic                 lanes_ready,
    output logic                 busy,
    output logic [COUNT_W-1:0]   issued_count
);

    localparam int ENTRY_W = INSTR_W + NUM_LANES;

    dispatch_state_e      state_reg;
    dispatch_state_e      state_next;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [ENTRY_W-1:0]   head_data;
    logic [INSTR_W-1:0]   head_instr;
    logic [NUM_LANES-1:0] head_mask;
    logic                 issue;

    logic                 execute_reg;
    logic [INSTR_W-1:0]   instruction_reg;
    logic [NUM_LANES-1:0] lane_enable_reg;
    logic [COUNT_W-1:0]   issued_count_reg;

    // Reset and flush both block new entries for the cycle they are asserted.
    assign in_ready  = !fifo_full && !flush && !rst;
    assign fifo_push = in_valid && in_ready;

    assign head_instr = head_data[INSTR_W-1:0];
    assign head_mask  = head_data[ENTRY_W-1:INSTR_W];

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (flush),
        .wdata ({in_mask, in_instr}),
        .rdata (head_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and pop decision; a flush suppresses any pop so the head is
    // dropped with the rest of the queue instead of being issued.
    always_comb begin
        state_next = state_reg;
        fifo_pop   = 1'b0;
        issue      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!fifo_empty && !flush) begin
                    if (head_mask == '0) begin
                        fifo_pop = 1'b1;
                    end else if (lanes_ready) begin
                        fifo_pop   = 1'b1;
                        issue      = 1'b1;
                        state_next = EXEC;
                    end
                end
            end
            EXEC: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (lanes_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Registered issue outputs: loaded on the edge that enters EXEC so they are
    // valid for the whole EXEC cycle; lane_enable drops when returning to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            execute_reg      <= 1'b0;
            instruction_reg  <= '0;
            lane_enable_reg  <= '0;
            issued_count_reg <= '0;
        end else begin
            execute_reg <= issue;
            if (issue) begin
                instruction_reg  <= head_instr;
                lane_enable_reg  <= head_mask;
                issued_count_reg <= count_inc(issued_count_reg);
            end else if (state_next == IDLE) begin
                lane_enable_reg <= '0;
            end
        end
    end

    assign execute      = execute_reg;
    assign instruction  = instruction_reg;
    assign lane_enable  = lane_enable_reg;
    assign issued_count = issued_count_reg;
    assign busy         = (state_reg != IDLE) || !fifo_empty;

endmodule
